wb_retire_multi: RTL and testbench

Parametrised multi-lane writeback/retire stage. It accepts up to NRET instructions per cycle from the MEM/WB pipeline registers and handles the following:

- selects each lane's result and masks writes behind traps, in program order;
- drives NRET regfile write ports and one CSR write port;
- keeps the minstret-increment and RVFI order counters;
- registers per-lane RVFI records.

It sits between the MEM/WB pipeline register bank and the regfile, CSR file and trap controller. It replaces the single-lane writeback stage in multi-issue configurations.

---
 rtl/wb_retire_multi_if.sv | 83 ++++++++
 rtl/wb_retire_multi.sv | 182 ++++++++++++++++++
 tb/tb_wb_retire_multi.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_multi_if.sv
// Types and port bundle for the multi-lane writeback/retire stage.
//   wb_retire_multi_pkg : MEM/WB record (mem_wb_t), trap info (trap_t), RVFI record (rvfi_t).
//   wb_retire_multi_if  : MEM/WB lanes and CSR masks in; regfile, CSR, trap, instret and RVFI out.
//   master drives the pipeline side; slave is the retire stage.
package wb_retire_multi_pkg;

    typedef enum logic [1:0] {
        ALU_RESULT      = 2'd0,
        MEM_DATA        = 2'd1,
        NEXT_INSTR_ADDR = 2'd2,
        CSR_READ_DATA   = 2'd3
    } result_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] cause;
    } trap_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [11:0] csr_addr;
        result_sel_e result_sel;
        logic [31:0] alu_csr_result;
        logic [31:0] load_rdata;
        logic [31:0] pc_plus_4;
        logic [31:0] csr_rdata;
        logic [31:0] csr_wdata;
        trap_t       carried_trap;
    } mem_wb_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic [31:0] csr_wmask;
        logic [31:0] csr_rmask;
        trap_t       trap;
    } rvfi_t;

endpackage

interface wb_retire_multi_if #(
    parameter int unsigned NRET    = 2,
    parameter int unsigned ORDER_W = 64
);
    import wb_retire_multi_pkg::*;

    localparam int unsigned TL_W  = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int unsigned INC_W = $clog2(NRET + 1);

    mem_wb_t            wb_pipeline_q  [NRET];
    logic [31:0]        wb_csr_rmask_i;
    logic [31:0]        wb_csr_wmask_i;
    logic [4:0]         wb_rd_addr_o   [NRET];
    logic [31:0]        wb_rd_wdata_o  [NRET];
    logic [11:0]        wb_csr_addr_o;
    logic [31:0]        wb_csr_wdata_o;
    logic               wb_trap_valid_o;
    logic [TL_W-1:0]    wb_trap_lane_o;
    logic [INC_W-1:0]   wb_instret_inc_o;
    rvfi_t              rvfi_o         [NRET];
    logic [ORDER_W-1:0] rvfi_order_o   [NRET];

    modport master (
        output wb_pipeline_q, wb_csr_rmask_i, wb_csr_wmask_i,
        input  wb_rd_addr_o, wb_rd_wdata_o, wb_csr_addr_o, wb_csr_wdata_o,
               wb_trap_valid_o, wb_trap_lane_o, wb_instret_inc_o, rvfi_o, rvfi_order_o
    );

    modport slave (
        input  wb_pipeline_q, wb_csr_rmask_i, wb_csr_wmask_i,
        output wb_rd_addr_o, wb_rd_wdata_o, wb_csr_addr_o, wb_csr_wdata_o,
               wb_trap_valid_o, wb_trap_lane_o, wb_instret_inc_o, rvfi_o, rvfi_order_o
    );

endinterface

// File: rtl/wb_retire_multi.sv
// Multi-lane writeback/retire stage (lane 0 oldest).
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   bus (slave)   : MEM/WB lanes in; regfile/CSR/trap/instret (combinational) and RVFI (registered) out.
// Optional feature macro RVFI_EN: builds RVFI registers, order counter and CSR multiplicity check;
// without it rvfi_o / rvfi_order_o are tied to 0.
module wb_retire_multi
    import wb_retire_multi_pkg::*;
#(
    parameter int unsigned NRET    = 2,
    parameter int unsigned ORDER_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wb_retire_multi_if.slave bus
);

    localparam int unsigned TL_W  = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int unsigned INC_W = $clog2(NRET + 1);

    logic [NRET-1:0]        live_c;
    logic [NRET-1:0]        trap_c;
    logic [NRET-1:0]        commit_c;
    logic [NRET-1:0]        csr_sel_c;
    logic                   csr_multi_c;
    logic [NRET-1:0][4:0]   rd_c;
    logic [NRET-1:0][11:0]  csr_c;
    logic [NRET-1:0][31:0]  res_c;
    logic [NRET-1:0][4:0]   rf_addr_c;
    logic [NRET-1:0][31:0]  rf_wdata_c;
    logic [11:0]            csr_addr_c;
    logic [31:0]            csr_wdata_c;
    logic                   trap_valid_c;
    logic [TL_W-1:0]        trap_lane_c;
    logic [INC_W-1:0]       inc_c;

    // Lane qualification in program order, result select, CSR port and instret.
    always_comb begin
        logic seen_trap;
        logic csr_found;
        seen_trap    = 1'b0;
        csr_found    = 1'b0;
        csr_multi_c  = 1'b0;
        csr_addr_c   = '0;
        csr_wdata_c  = '0;
        trap_valid_c = 1'b0;
        trap_lane_c  = '0;
        inc_c        = '0;
        for (int k = 0; k < NRET; k++) begin
            live_c[k]    = bus.wb_pipeline_q[k].valid && !seen_trap;
            trap_c[k]    = live_c[k] && bus.wb_pipeline_q[k].carried_trap.valid;
            commit_c[k]  = live_c[k] && !bus.wb_pipeline_q[k].carried_trap.valid;
            if (bus.wb_pipeline_q[k].valid && bus.wb_pipeline_q[k].carried_trap.valid) begin
                seen_trap = 1'b1;
            end
            // only the first trapping lane can be live, so this fires at most once
            if (trap_c[k]) begin
                trap_valid_c = 1'b1;
                trap_lane_c  = TL_W'(k);
            end
            rd_c[k]  = commit_c[k] ? bus.wb_pipeline_q[k].rd_addr  : 5'd0;
            csr_c[k] = commit_c[k] ? bus.wb_pipeline_q[k].csr_addr : 12'd0;
            res_c[k] = '0;
            case (bus.wb_pipeline_q[k].result_sel)
                ALU_RESULT:      res_c[k] = bus.wb_pipeline_q[k].alu_csr_result;
                MEM_DATA:        res_c[k] = bus.wb_pipeline_q[k].load_rdata;
                NEXT_INSTR_ADDR: res_c[k] = bus.wb_pipeline_q[k].pc_plus_4;
                CSR_READ_DATA:   res_c[k] = bus.wb_pipeline_q[k].csr_rdata;
                default:         res_c[k] = '0;
            endcase
            csr_sel_c[k] = (csr_c[k] != 12'd0) && !csr_found;
            if ((csr_c[k] != 12'd0) && csr_found) begin
                csr_multi_c = 1'b1;
            end
            if (csr_sel_c[k]) begin
                csr_found   = 1'b1;
                csr_addr_c  = csr_c[k];
                csr_wdata_c = bus.wb_pipeline_q[k].csr_wdata;
            end
            if (commit_c[k]) begin
                inc_c = inc_c + INC_W'(1);
            end
        end
    end

    // WAW inside a group: a younger committing write to the same rd suppresses the older port.
    always_comb begin
        logic waw;
        for (int k = 0; k < NRET; k++) begin
            waw = 1'b0;
            for (int j = k + 1; j < NRET; j++) begin
                if ((rd_c[k] != 5'd0) && (rd_c[j] == rd_c[k])) begin
                    waw = 1'b1;
                end
            end
            rf_addr_c[k]  = waw ? 5'd0 : rd_c[k];
            rf_wdata_c[k] = (rf_addr_c[k] != 5'd0) ? res_c[k] : 32'd0;
        end
    end

    assign bus.wb_csr_addr_o    = csr_addr_c;
    assign bus.wb_csr_wdata_o   = csr_wdata_c;
    assign bus.wb_trap_valid_o  = trap_valid_c;
    assign bus.wb_trap_lane_o   = trap_lane_c;
    assign bus.wb_instret_inc_o = inc_c;

`ifdef RVFI_EN
    rvfi_t              rvfi_d       [NRET];
    rvfi_t              rvfi_q       [NRET];
    logic [ORDER_W-1:0] rvfi_order_d [NRET];
    logic [ORDER_W-1:0] rvfi_order_q [NRET];
    logic [ORDER_W-1:0] order_d;
    logic [ORDER_W-1:0] order_q;

    // RVFI records; non-live lanes are emitted as all-zero records.
    always_comb begin
        logic [ORDER_W-1:0] cnt;
        cnt = order_q;
        for (int k = 0; k < NRET; k++) begin
            rvfi_d[k]       = '0;
            rvfi_order_d[k] = '0;
            if (live_c[k]) begin
                rvfi_d[k].valid     = 1'b1;
                rvfi_d[k].insn      = bus.wb_pipeline_q[k].insn;
                rvfi_d[k].pc_rdata  = bus.wb_pipeline_q[k].pc;
                rvfi_d[k].rd_addr   = rd_c[k];
                rvfi_d[k].rd_wdata  = (rd_c[k] != 5'd0) ? res_c[k] : 32'd0;
                rvfi_d[k].csr_addr  = csr_c[k];
                rvfi_d[k].csr_wdata = (csr_c[k] != 12'd0) ? bus.wb_pipeline_q[k].csr_wdata : 32'd0;
                if (csr_sel_c[k]) begin
                    rvfi_d[k].csr_wmask = bus.wb_csr_wmask_i;
                    rvfi_d[k].csr_rmask = bus.wb_csr_rmask_i;
                end
                if (trap_c[k]) begin
                    rvfi_d[k].trap = bus.wb_pipeline_q[k].carried_trap;
                end
                rvfi_order_d[k] = cnt;
                cnt             = cnt + ORDER_W'(1);
            end
        end
        order_d = cnt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q <= '0;
            for (int k = 0; k < NRET; k++) begin
                rvfi_q[k]       <= '0;
                rvfi_order_q[k] <= '0;
            end
        end else begin
            order_q <= order_d;
            for (int k = 0; k < NRET; k++) begin
                rvfi_q[k]       <= rvfi_d[k];
                rvfi_order_q[k] <= rvfi_order_d[k];
            end
        end
    end

    // Issue guarantees at most one CSR-writing committing lane per group.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !csr_multi_c);
`else
    logic unused_c;
    assign unused_c = ^{clk_i, rst_ni, bus.wb_csr_rmask_i, bus.wb_csr_wmask_i,
                        csr_multi_c, csr_sel_c, trap_c};
`endif

    for (genvar k = 0; k < NRET; k++) begin : g_lane
        assign bus.wb_rd_addr_o[k]  = rf_addr_c[k];
        assign bus.wb_rd_wdata_o[k] = rf_wdata_c[k];
`ifdef RVFI_EN
        assign bus.rvfi_o[k]        = rvfi_q[k];
        assign bus.rvfi_order_o[k]  = rvfi_order_q[k];
`else
        logic unused_lane_c;
        assign unused_lane_c        = ^{bus.wb_pipeline_q[k].pc, bus.wb_pipeline_q[k].insn,
                                        bus.wb_pipeline_q[k].carried_trap.cause};
        assign bus.rvfi_o[k]        = '0;
        assign bus.rvfi_order_o[k]  = '0;
`endif
    end

endmodule

// File: tb/tb_wb_retire_multi.sv
// Bench for wb_retire_multi: directed vector table, random groups against a reference model,
// mid-stream reset and order-counter wrap (second instance with a 2-bit order counter).
module tb_wb_retire_multi;
    import wb_retire_multi_pkg::*;

`ifdef RVFI_EN
    localparam bit RV_ON = 1'b1;
`else
    localparam bit RV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_retire_multi_if #(.NRET(2), .ORDER_W(64)) bus_a ();
    wb_retire_multi_if #(.NRET(2), .ORDER_W(2))  bus_b ();

    wb_retire_multi #(.NRET(2), .ORDER_W(64)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave));
    wb_retire_multi #(.NRET(2), .ORDER_W(2))  dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0][4:0]  rd;
        logic [1:0][31:0] wd;
        logic [11:0]      csr_addr;
        logic [31:0]      csr_wdata;
        logic             trap_valid;
        logic             trap_lane;
        logic [1:0]       inc;
        rvfi_t [1:0]      rvfi;
        logic [1:0][63:0] ord_a;
        logic [1:0][1:0]  ord_b;
        logic [63:0]      next_a;
        logic [1:0]       next_b;
    } exp_t;

    typedef struct {
        mem_wb_t     g0, g1;
        logic [31:0] rm, wm;
        logic [4:0]  rd0, rd1;
        logic [31:0] wd0, wd1;
        logic [1:0]  inc;
        logic        tv, tl;
        logic [11:0] ca;
        logic [31:0] cw;
    } vec_t;

    logic [63:0] ord_a = '0;
    logic [1:0]  ord_b = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mem_wb_t mk(bit v, logic [4:0] rd, result_sel_e sel, logic [31:0] res,
                                   logic [11:0] ca, logic [31:0] cw, bit tv);
        mem_wb_t m;
        m                = '0;
        m.valid          = v;
        m.pc             = 32'h0000_0100;
        m.insn           = 32'h0000_0013 | {20'd0, rd, 7'd0};
        m.rd_addr        = rd;
        m.result_sel     = sel;
        m.alu_csr_result = 32'hA1A1_0000;
        m.load_rdata     = 32'hB2B2_0000;
        m.pc_plus_4      = 32'h0000_0104;
        m.csr_rdata      = 32'hC3C3_0000;
        case (sel)
            ALU_RESULT:      m.alu_csr_result = res;
            MEM_DATA:        m.load_rdata     = res;
            NEXT_INSTR_ADDR: m.pc_plus_4      = res;
            default:         m.csr_rdata      = res;
        endcase
        m.csr_addr           = ca;
        m.csr_wdata          = cw;
        m.carried_trap.valid = tv;
        m.carried_trap.cause = tv ? 32'd2 : 32'd0;
        return m;
    endfunction

    function automatic logic [31:0] pick(mem_wb_t m);
        case (m.result_sel)
            ALU_RESULT:      return m.alu_csr_result;
            MEM_DATA:        return m.load_rdata;
            NEXT_INSTR_ADDR: return m.pc_plus_4;
            default:         return m.csr_rdata;
        endcase
    endfunction

    // Reference: t = oldest valid trapping lane; lanes below t commit, lane t retires as a trap.
    function automatic exp_t model(mem_wb_t g0, mem_wb_t g1, logic [31:0] rm, logic [31:0] wm,
                                   logic [63:0] oa, logic [1:0] ob);
        exp_t    e;
        mem_wb_t g[2];
        int      t, csr_k, n;
        bit      commit[2];
        bit      live[2];
        e = '0; g[0] = g0; g[1] = g1; t = 2; csr_k = -1; n = 0;
        for (int k = 1; k >= 0; k--) if (g[k].valid && g[k].carried_trap.valid) t = k;
        e.trap_valid = (t < 2);
        e.trap_lane  = (t == 1);
        for (int k = 0; k < 2; k++) begin
            live[k]   = g[k].valid && (k <= t);
            commit[k] = g[k].valid && (k < t);
            if (commit[k]) e.inc = e.inc + 2'd1;
            if (commit[k] && g[k].csr_addr != 0 && csr_k < 0) csr_k = k;
        end
        for (int k = 0; k < 2; k++) begin
            bit shadowed = 1'b0;
            for (int j = k + 1; j < 2; j++)
                if (commit[j] && g[j].rd_addr == g[k].rd_addr) shadowed = 1'b1;
            if (commit[k] && g[k].rd_addr != 0 && !shadowed) begin
                e.rd[k] = g[k].rd_addr;
                e.wd[k] = pick(g[k]);
            end
        end
        if (csr_k >= 0) begin
            e.csr_addr  = g[csr_k].csr_addr;
            e.csr_wdata = g[csr_k].csr_wdata;
        end
        for (int k = 0; k < 2; k++) begin
            if (live[k] && RV_ON) begin
                e.rvfi[k].valid    = 1'b1;
                e.rvfi[k].insn     = g[k].insn;
                e.rvfi[k].pc_rdata = g[k].pc;
                if (commit[k] && g[k].rd_addr != 0) begin
                    e.rvfi[k].rd_addr  = g[k].rd_addr;
                    e.rvfi[k].rd_wdata = pick(g[k]);
                end
                if (commit[k] && g[k].csr_addr != 0) begin
                    e.rvfi[k].csr_addr  = g[k].csr_addr;
                    e.rvfi[k].csr_wdata = g[k].csr_wdata;
                end
                if (k == csr_k) begin
                    e.rvfi[k].csr_wmask = wm;
                    e.rvfi[k].csr_rmask = rm;
                end
                if (k == t) e.rvfi[k].trap = g[k].carried_trap;
                e.ord_a[k] = oa + 64'(n);
                e.ord_b[k] = ob + 2'(n);
            end
            if (live[k]) n++;
        end
        e.next_a = oa + 64'(n);
        e.next_b = ob + 2'(n);
        return e;
    endfunction

    task automatic apply(input mem_wb_t g0, input mem_wb_t g1, input logic [31:0] rm, input logic [31:0] wm);
        bus_a.wb_pipeline_q[0] = g0; bus_a.wb_pipeline_q[1] = g1;
        bus_b.wb_pipeline_q[0] = g0; bus_b.wb_pipeline_q[1] = g1;
        bus_a.wb_csr_rmask_i = rm; bus_a.wb_csr_wmask_i = wm;
        bus_b.wb_csr_rmask_i = rm; bus_b.wb_csr_wmask_i = wm;
    endtask

    task automatic drive(input mem_wb_t g0, input mem_wb_t g1, input logic [31:0] rm, input logic [31:0] wm);
        @(negedge clk);
        apply(g0, g1, rm, wm);
        #1;
    endtask

    task automatic check_comb();
        exp_t e;
        e = model(bus_a.wb_pipeline_q[0], bus_a.wb_pipeline_q[1], bus_a.wb_csr_rmask_i,
                  bus_a.wb_csr_wmask_i, ord_a, ord_b);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_addr%0d", k), 256'(bus_a.wb_rd_addr_o[k]), 256'(e.rd[k]));
            chk($sformatf("rd_wdata%0d", k), 256'(bus_a.wb_rd_wdata_o[k]), 256'(e.wd[k]));
        end
        chk("csr_addr", 256'(bus_a.wb_csr_addr_o), 256'(e.csr_addr));
        chk("csr_wdata", 256'(bus_a.wb_csr_wdata_o), 256'(e.csr_wdata));
        chk("trap", 256'({bus_a.wb_trap_valid_o, bus_a.wb_trap_lane_o}), 256'({e.trap_valid, e.trap_lane}));
        chk("instret", 256'(bus_a.wb_instret_inc_o), 256'(e.inc));
    endtask

    // Model the held group, then check what the edge captured.
    task automatic check_rvfi();
        exp_t e;
        e = model(bus_a.wb_pipeline_q[0], bus_a.wb_pipeline_q[1], bus_a.wb_csr_rmask_i,
                  bus_a.wb_csr_wmask_i, ord_a, ord_b);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rvfi%0d", k), 256'(bus_a.rvfi_o[k]), 256'(e.rvfi[k]));
            chk($sformatf("order%0d", k), 256'(bus_a.rvfi_order_o[k]), 256'(e.ord_a[k]));
            chk($sformatf("order_w2_%0d", k), 256'(bus_b.rvfi_order_o[k]), 256'(e.ord_b[k]));
        end
        ord_a = e.next_a;
        ord_b = e.next_b;
    endtask

    mem_wb_t nop;
    vec_t    tab[10];
    mem_wb_t ga0, ga1;

    initial begin
        nop = mk(1'b0, 5'd0, ALU_RESULT, 32'd0, 12'd0, 32'd0, 1'b0);
        apply(nop, nop, 32'd0, 32'd0);

        // reset state
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rvfi", 256'(bus_a.rvfi_o[k]), 256'(0));
            chk("rst_order", 256'(bus_a.rvfi_order_o[k]), 256'(0));
        end
        @(negedge clk); rst_n = 1'b1;

        tab[0] = '{mk(1, 5, ALU_RESULT, 32'h10, 0, 0, 0), mk(1, 6, MEM_DATA, 32'hDEADBEEF, 0, 0, 0),
                   0, 0, 5, 6, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0};
        tab[1] = '{mk(1, 7, ALU_RESULT, 32'h99, 0, 0, 1), mk(1, 8, ALU_RESULT, 32'h88, 0, 0, 0),
                   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tab[2] = '{mk(1, 3, ALU_RESULT, 32'hA, 0, 0, 0), mk(1, 3, MEM_DATA, 32'hB, 0, 0, 0),
                   0, 0, 0, 3, 0, 32'hB, 2, 0, 0, 0, 0};
        tab[3] = '{mk(1, 1, ALU_RESULT, 32'h1, 0, 0, 0), mk(1, 9, CSR_READ_DATA, 32'h77, 12'h340, 32'h55, 0),
                   32'h0, 32'hFFFFFFFF, 1, 9, 32'h1, 32'h77, 2, 0, 0, 12'h340, 32'h55};
        tab[4] = '{nop, nop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[5] = '{mk(1, 4, ALU_RESULT, 32'h44, 0, 0, 0), mk(1, 2, MEM_DATA, 32'h66, 0, 0, 1),
                   0, 0, 4, 0, 32'h44, 0, 1, 1, 1, 0, 0};
        tab[6] = '{mk(0, 3, ALU_RESULT, 32'h5, 0, 0, 0), mk(1, 2, NEXT_INSTR_ADDR, 32'h2222, 0, 0, 0),
                   0, 0, 0, 2, 0, 32'h2222, 1, 0, 0, 0, 0};
        tab[7] = '{mk(0, 3, ALU_RESULT, 32'h5, 12'h340, 32'h1, 1), mk(1, 2, ALU_RESULT, 32'h22, 0, 0, 0),
                   0, 0, 0, 2, 0, 32'h22, 1, 0, 0, 0, 0};
        tab[8] = '{mk(1, 7, ALU_RESULT, 32'h1, 12'h340, 32'h9, 1), mk(1, 0, ALU_RESULT, 32'h0, 0, 0, 0),
                   0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tab[9] = '{mk(1, 0, ALU_RESULT, 32'h3, 0, 0, 0), mk(1, 0, MEM_DATA, 32'h4, 0, 0, 0),
                   0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            drive(tab[i].g0, tab[i].g1, tab[i].rm, tab[i].wm);
            chk($sformatf("v%0d_rd", i), 256'({bus_a.wb_rd_addr_o[0], bus_a.wb_rd_addr_o[1]}),
                256'({tab[i].rd0, tab[i].rd1}));
            chk($sformatf("v%0d_wd", i), 256'({bus_a.wb_rd_wdata_o[0], bus_a.wb_rd_wdata_o[1]}),
                256'({tab[i].wd0, tab[i].wd1}));
            chk($sformatf("v%0d_inc", i), 256'(bus_a.wb_instret_inc_o), 256'(tab[i].inc));
            chk($sformatf("v%0d_trap", i), 256'({bus_a.wb_trap_valid_o, bus_a.wb_trap_lane_o}),
                256'({tab[i].tv, tab[i].tl}));
            chk($sformatf("v%0d_csr", i), 256'({bus_a.wb_csr_addr_o, bus_a.wb_csr_wdata_o}),
                256'({tab[i].ca, tab[i].cw}));
            check_rvfi();
            if (i == 3) begin
                chk("csr_wmask1", 256'(bus_a.rvfi_o[1].csr_wmask), 256'(RV_ON ? 32'hFFFFFFFF : 32'h0));
                chk("csr_wmask0", 256'(bus_a.rvfi_o[0].csr_wmask), 256'(0));
            end
        end

        // random groups, at most one CSR lane each
        for (int n = 0; n < 400; n++) begin
            mem_wb_t g[2];
            int      csr_lane;
            csr_lane = $urandom_range(0, 3);
            for (int k = 0; k < 2; k++) begin
                g[k] = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                          result_sel_e'(2'($urandom_range(0, 3))), $urandom,
                          (csr_lane == k) ? 12'($urandom_range(1, 4095)) : 12'd0, $urandom,
                          $urandom_range(0, 4) == 0);
                g[k].pc   = $urandom;
                g[k].insn = $urandom;
            end
            drive(g[0], g[1], $urandom, $urandom);
            check_comb();
            check_rvfi();
        end

        // reset asserted while a valid group is presented
        ga0 = mk(1, 10, ALU_RESULT, 32'h1234, 0, 0, 0);
        ga1 = mk(1, 11, MEM_DATA, 32'h5678, 0, 0, 0);
        drive(ga0, ga1, 0, 0);
        check_rvfi();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_rvfi", 256'(bus_a.rvfi_o[k]), 256'(0));
            chk("midrst_order", 256'(bus_a.rvfi_order_o[k]), 256'(0));
        end
        @(posedge clk); #1;
        chk("midrst_hold", 256'({bus_a.rvfi_o[0], bus_a.rvfi_o[1]}), 256'(0));
        @(negedge clk);
        apply(nop, nop, 0, 0);
        rst_n = 1'b1;
        ord_a = '0;
        ord_b = '0;
        check_rvfi();
        drive(ga0, ga1, 0, 0);
        check_rvfi();
        chk("postrst_ord", 256'({bus_a.rvfi_order_o[0], bus_a.rvfi_order_o[1]}),
            256'({64'd0, RV_ON ? 64'd1 : 64'd0}));

        // wrap of the 2-bit counter: order_q = 3, retire 2 lanes
        drive(ga0, nop, 0, 0);
        check_rvfi();
        drive(ga0, ga1, 0, 0);
        check_rvfi();
        chk("wrap_ord", 256'({bus_b.rvfi_order_o[0], bus_b.rvfi_order_o[1]}),
            256'({RV_ON ? 2'd3 : 2'd0, 2'd0}));
        drive(ga0, nop, 0, 0);
        check_rvfi();
        chk("wrap_next", 256'(bus_b.rvfi_order_o[0]), 256'(RV_ON ? 2'd1 : 2'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
